// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop consume one operand
// bit per clock, LSB first, and the result is published when the last bit is done.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_sum;
  logic             r_c, r_done, r_carry, r_overflow;
  logic [CntW-1:0]  r_cnt;

  logic             w_accept, w_last, w_s, w_cout;
  logic [WIDTH:0]   w_cat;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept   = (r_state != StRun) && i_start;
  assign w_last     = (r_state == StRun) && (r_cnt == CntW'(WIDTH - 1));
  assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cout     = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign w_cat      = {w_s, r_res};
  assign w_res_next = w_cat[WIDTH:1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = i_start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_c        <= 1'b0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Subtraction is a + ~b + 1: invert B here and seed the carry with 1.
        r_a   <= i_a;
        r_b   <= i_b ^ {WIDTH{i_sub}};
        r_c   <= i_sub;
        r_res <= '0;
        r_cnt <= '0;
      end else if (r_state == StRun) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_c   <= w_cout;
        r_res <= w_res_next;
        r_cnt <= r_cnt + CntW'(1);
        if (w_last) begin
          r_sum      <= w_res_next;
          r_carry    <= w_cout;
          r_overflow <= r_c ^ w_cout;
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = (r_state == StRun);
  assign o_done     = r_done;
  assign o_sum      = r_sum;
  assign o_carry    = r_carry;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit and a 1-bit instance checked every cycle against an
// arithmetic model, plus directed vectors with hand-computed results and latencies.
module tb_serial_adder;

  typedef struct packed {
    logic       run;
    int         left;
    logic       done;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
    logic [7:0] p_sum;
    logic       p_c;
    logic       p_o;
  } model_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, carry8, ovf8;
  logic [7:0] sum8;
  logic       start1 = 1'b0, sub1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, carry1, ovf1;
  logic [0:0] sum1;

  int n_checks = 0;
  int n_errors = 0;
  model_t m8, m1;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_sub(sub8), .i_a(a8), .i_b(b8),
    .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_carry(carry8), .o_overflow(ovf8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_sub(sub1), .i_a(a1), .i_b(b1),
    .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_carry(carry1), .o_overflow(ovf1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a result computed with plain arithmetic appears w edges after
  // acceptance; start is only honoured while not running.
  function automatic model_t step(model_t m, logic start, int a, int b, logic sub, int w);
    model_t n;
    int mask, bp, full, msb;
    n = m;
    n.done = 1'b0;
    if (m.run) begin
      n.left = m.left - 1;
      if (n.left == 0) begin
        n.run   = 1'b0;
        n.done  = 1'b1;
        n.sum   = m.p_sum;
        n.carry = m.p_c;
        n.ovf   = m.p_o;
      end
    end else if (start) begin
      mask    = (1 << w) - 1;
      bp      = sub ? (~b & mask) : (b & mask);
      full    = (a & mask) + bp + int'(sub);
      msb     = w - 1;
      n.run   = 1'b1;
      n.left  = w;
      n.p_sum = 8'(full & mask);
      n.p_c   = ((full >> w) & 1) != 0;
      n.p_o   = (((a >> msb) & 1) == ((bp >> msb) & 1)) &&
                (((full >> msb) & 1) != ((a >> msb) & 1));
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 <= '0;
      m1 <= '0;
    end else begin
      m8 <= step(m8, start8, int'(a8), int'(b8), sub8, 8);
      m1 <= step(m1, start1, int'(a1), int'(b1), sub1, 1);
    end
  end

  always @(negedge clk) begin
    chk("busy8", int'(busy8), int'(m8.run));
    chk("done8", int'(done8), int'(m8.done));
    chk("sum8", int'(sum8), int'(m8.sum));
    chk("carry8", int'(carry8), int'(m8.carry));
    chk("ovf8", int'(ovf8), int'(m8.ovf));
    chk("busy1", int'(busy1), int'(m1.run));
    chk("done1", int'(done1), int'(m1.done));
    chk("sum1", int'(sum1), int'(m1.sum[0]));
    chk("carry1", int'(carry1), int'(m1.carry));
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input int es, input int ec, input int eo, input string tag);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      start8 = 1'b0;
    end while (!done8 && n < 30);
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_sum"}, int'(sum8), es);
    chk({tag, "_carry"}, int'(carry8), ec);
    chk({tag, "_ovf"}, int'(ovf8), eo);
  endtask

  task automatic run1(input logic a, input logic b, input int es, input int ec,
                      input string tag);
    int n;
    @(negedge clk);
    a1 = a; b1 = b; sub1 = 1'b0; start1 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      start1 = 1'b0;
    end while (!done1 && n < 10);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_sum"}, int'(sum1), es);
    chk({tag, "_carry"}, int'(carry1), ec);
  endtask

  initial begin
    int n, nbusy;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    chk("rst_sum", int'(sum8), 0);
    rst_n = 1'b1;

    run8(8'h5A, 8'h3C, 1'b0, 'h96, 0, 1, "add_5a_3c");
    run8(8'hFF, 8'h01, 1'b0, 'h00, 1, 0, "add_ff_01");
    run8(8'h10, 8'h20, 1'b1, 'hF0, 0, 0, "sub_10_20");
    run8(8'h80, 8'h01, 1'b1, 'h7F, 1, 1, "sub_80_01");

    // Start during RUN is ignored; then start held in DONE chains a new operation.
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    n = 0; nbusy = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (busy8) nbusy++;
      start8 = 1'b0;
      if (n == 4) begin a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1; end
    end while (!done8 && n < 30);
    chk("ignore_lat", n, 9);
    chk("ignore_busy_cycles", nbusy, 8);
    chk("ignore_sum", int'(sum8), 'h02);
    a8 = 8'h03; b8 = 8'h04; start8 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      start8 = 1'b0;
    end while (!done8 && n < 30);
    chk("chain_lat", n, 9);
    chk("chain_sum", int'(sum8), 'h07);

    // Reset part-way through an operation.
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; start8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy8), 0);
    chk("abort_sum", int'(sum8), 0);
    chk("abort_done", int'(done8), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", int'(done8), 0);
    end
    run8(8'h0F, 8'h01, 1'b0, 'h10, 0, 0, "after_rst");

    run1(1'b0, 1'b0, 0, 0, "w1_00");
    run1(1'b1, 1'b0, 1, 0, "w1_10");
    run1(1'b0, 1'b1, 1, 0, "w1_01");
    run1(1'b1, 1'b1, 0, 1, "w1_11");

    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
